// File: rtl/apb_cfg_master.sv
// ---------------------------------------------------------------------------
// apb_cfg_master
//   APB initiator that turns a command/response stream into APB writes, reads
//   or poll loops (repeated reads until (PRDATA & mask) != 0) against the TPU
//   configuration register block.
//
// Ports
//   PCLK, PRESET            clock (rising edge) / asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write, cmd_poll     1=write / 0=read; poll repeats reads until match
//   cmd_addr, cmd_wdata     register address and write data
//   cmd_mask                poll match mask
//   rsp_valid/rsp_ready     response handshake (valid held until ready)
//   rsp_rdata, rsp_status   last sampled PRDATA; 00 ok, 01 timeout, 10 poll exhausted
//   PADDR..PWDATA, PRDATA,
//   PREADY                  APB initiator interface
// ---------------------------------------------------------------------------
module apb_cfg_master #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255,
  parameter int POLL_MAX = 1024
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_poll,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int         PCW      = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TMO = 2'b01;
  localparam logic [1:0] ST_EXH = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_GAP    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic              r_psel;
  logic              r_penable;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_mask;
  logic              r_poll;
  logic [7:0]        r_tmo;
  logic [PCW-1:0]    r_poll_cnt;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [1:0]        r_rsp_status;

  logic              w_cmd_ready_nxt;
  logic              w_rsp_valid_nxt;
  logic              w_psel_nxt;
  logic              w_penable_nxt;

  logic              w_accept;
  logic              w_in_access;
  logic              w_match;
  logic              w_poll_more;
  logic              w_tmo_hit;

  assign w_accept    = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;
  assign w_in_access = (r_state == S_ACCESS);
  assign w_match     = |(PRDATA & r_mask);
  // Limit is checked before the increment, so poll_cnt never wraps.
  assign w_poll_more = (int'(r_poll_cnt) < (POLL_MAX - 1));
  assign w_tmo_hit   = (r_tmo == TMO_LAST);

  // State register plus registered FSM outputs (PSEL/PENABLE drop asynchronously).
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (r_poll && !w_match && w_poll_more) begin
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_RESP;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_GAP: begin
        w_state_nxt = S_SETUP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state; registered above so outputs track the state.
  always_comb begin
    w_cmd_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_psel_nxt      = 1'b0;
    w_penable_nxt   = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
      end
      S_SETUP: begin
        w_psel_nxt = 1'b1;
      end
      S_ACCESS: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
      end
      S_GAP: begin
        w_psel_nxt = 1'b0;
      end
      S_RESP: begin
        w_rsp_valid_nxt = 1'b1;
      end
      default: begin
        w_cmd_ready_nxt = 1'b0;
      end
    endcase
  end

  // Command latch; a write never polls.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_mask   <= '0;
      r_poll   <= 1'b0;
    end else if (w_accept) begin
      r_paddr  <= cmd_addr;
      r_pwrite <= cmd_write;
      r_pwdata <= cmd_wdata;
      r_mask   <= cmd_mask;
      r_poll   <= cmd_poll & ~cmd_write;
    end else begin
      r_paddr  <= r_paddr;
      r_pwrite <= r_pwrite;
      r_pwdata <= r_pwdata;
      r_mask   <= r_mask;
      r_poll   <= r_poll;
    end
  end

  // PREADY timeout counter (per transfer) and poll read counter (per command).
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tmo      <= 8'd0;
      r_poll_cnt <= '0;
    end else begin
      if (w_state_nxt == S_SETUP) begin
        r_tmo <= 8'd0;
      end else if (w_in_access) begin
        r_tmo <= r_tmo + 8'd1;
      end else begin
        r_tmo <= r_tmo;
      end
      if (w_accept) begin
        r_poll_cnt <= '0;
      end else if (r_state == S_GAP) begin
        r_poll_cnt <= r_poll_cnt + {{(PCW-1){1'b0}}, 1'b1};
      end else begin
        r_poll_cnt <= r_poll_cnt;
      end
    end
  end

  // Response capture: PRDATA on PREADY (0 for writes), 0 on timeout.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_rsp_rdata  <= '0;
      r_rsp_status <= ST_OK;
    end else if (w_in_access && PREADY) begin
      r_rsp_rdata  <= r_pwrite ? '0 : PRDATA;
      r_rsp_status <= (r_poll && !w_match && !w_poll_more) ? ST_EXH : ST_OK;
    end else if (w_in_access && w_tmo_hit) begin
      r_rsp_rdata  <= '0;
      r_rsp_status <= ST_TMO;
    end else begin
      r_rsp_rdata  <= r_rsp_rdata;
      r_rsp_status <= r_rsp_status;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_status = r_rsp_status;
  assign PADDR      = r_paddr;
  assign PWRITE     = r_pwrite;
  assign PSEL       = r_psel;
  assign PENABLE    = r_penable;
  assign PWDATA     = r_pwdata;

endmodule

// File: tb/tb_apb_cfg_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cfg_master
//   Scoreboard bench for apb_cfg_master. Each issued command pushes a plan
//   (for the APB slave model) and an expected response (from a behavioural
//   model of the command). The slave model answers transfers from the plan
//   and checks bus rules; a monitor pops and compares on each response
//   handshake.
// ---------------------------------------------------------------------------
module tb_apb_cfg_master;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int TMO  = 255;
  localparam int PMAX = 1024;

  logic          PCLK;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic          cmd_poll;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] cmd_mask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  apb_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .POLL_MAX(PMAX)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_poll(cmd_poll), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  // wait_c < 0 means the slave never raises PREADY; match_at = 0 means a poll never matches.
  typedef struct {
    logic          wr;
    logic          poll;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mask;
    logic [DW-1:0] base;
    int            wait_c;
    int            match_at;
  } plan_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    status;
    int            xfers;
    int            acc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  plan_t cur;
  exp_t  mon_e;
  int    vectors;
  int    miscompares;
  int    plans_started;
  int    rsp_done;
  int    abandons;
  int    xfers;
  int    acc;
  logic  exp_low;
  logic  rdy_mode;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave read data for the i-th read of a command (1-based).
  function automatic logic [DW-1:0] pdata(input plan_t p, input int i);
    logic [DW-1:0] v;
    if (p.wr || !p.poll) return p.base;
    v = (p.base ^ (32'(i) * 32'h9E37_79B9)) & ~p.mask;
    if (i == p.match_at) v = v | (p.mask & (~p.mask + 32'd1));
    return v;
  endfunction

  // Expected response of a command, straight from the command semantics.
  function automatic exp_t model(input plan_t p);
    exp_t e;
    int   n;
    if (p.wait_c < 0) begin
      e.rdata = 32'd0; e.status = 2'b01; e.xfers = 1; e.acc = TMO;
    end else if (p.wr || !p.poll) begin
      e.rdata = p.wr ? 32'd0 : p.base; e.status = 2'b00; e.xfers = 1; e.acc = p.wait_c + 1;
    end else begin
      if (p.match_at >= 1 && p.match_at <= PMAX) begin
        n = p.match_at; e.status = 2'b00;
      end else begin
        n = PMAX; e.status = 2'b10;
      end
      e.rdata = pdata(p, n); e.xfers = n; e.acc = p.wait_c + 1;
    end
    return e;
  endfunction

  function automatic plan_t mk(input logic wr, input logic poll, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] mask,
                               input logic [DW-1:0] base, input int wait_c, input int match_at);
    plan_t p;
    p.wr = wr; p.poll = poll; p.addr = addr; p.wdata = wdata; p.mask = mask;
    p.base = base; p.wait_c = wait_c; p.match_at = match_at;
    return p;
  endfunction

  // APB slave model and bus-rule checks.
  always @(negedge PCLK) begin
    if (PRESET) begin
      PREADY  = 1'b0;
      exp_low = 1'b0;
    end else begin
      if (exp_low) begin
        chk("psel_drop", 64'(PSEL), 64'd0);
        exp_low = 1'b0;
      end
      if (PENABLE) chk("penable_without_psel", 64'(PSEL), 64'd1);
      PREADY = 1'b0;
      PRDATA = $urandom;
      if (PSEL && !PENABLE) begin
        if (plans_started == rsp_done + abandons) begin
          if (plan_q.size() == 0) begin
            chk("plan_available", 64'd0, 64'd1);
          end else begin
            cur = plan_q.pop_front();
            plans_started++;
            xfers = 0;
          end
        end
        xfers++;
        acc = 0;
        chk("setup_paddr", 64'(PADDR), 64'(cur.addr));
        chk("setup_pwrite", 64'(PWRITE), 64'(cur.wr));
        if (cur.wr) chk("setup_pwdata", 64'(PWDATA), 64'(cur.wdata));
      end else if (PSEL && PENABLE) begin
        acc++;
        chk("access_paddr", 64'(PADDR), 64'(cur.addr));
        if (cur.wr) chk("access_pwdata", 64'(PWDATA), 64'(cur.wdata));
        if (cur.wait_c >= 0 && acc == cur.wait_c + 1) begin
          PREADY  = 1'b1;
          PRDATA  = pdata(cur, xfers);
          exp_low = 1'b1;
        end else if (acc >= TMO) begin
          exp_low = 1'b1;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake.
  always @(negedge PCLK) begin
    if (!PRESET && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        chk("rsp_status", 64'(rsp_status), 64'(mon_e.status));
        chk("apb_transfers", 64'(xfers), 64'(mon_e.xfers));
        chk("access_cycles", 64'(acc), 64'(mon_e.acc));
      end
      rsp_done++;
    end
  end

  // Response consumer: random back-pressure, or held low.
  always @(posedge PCLK) begin
    #1;
    rsp_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic issue(input plan_t p);
    int   n;
    logic ok;
    plan_q.push_back(p);
    exp_q.push_back(model(p));
    cmd_valid = 1'b1; cmd_write = p.wr; cmd_poll = p.poll;
    cmd_addr = p.addr; cmd_wdata = p.wdata; cmd_mask = p.mask;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20000) begin
      @(negedge PCLK);
      ok = cmd_ready;
      @(posedge PCLK);
      #1;
      n++;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_poll = 1'($urandom);
    cmd_addr = 8'($urandom); cmd_wdata = $urandom; cmd_mask = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge PCLK);
      n++;
    end
    #1;
    chk("idle_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    plan_t a;
    plan_t b;
    plan_t p;
    exp_t  ea;
    int    n;
    int    k;
    vectors = 0; miscompares = 0; plans_started = 0; rsp_done = 0; abandons = 0;
    xfers = 0; acc = 0; exp_low = 1'b0; rdy_mode = 1'b1; rsp_ready = 1'b0;
    PRESET = 1'b1; PREADY = 1'b0; PRDATA = 32'd0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_poll = 1'b0;
    cmd_addr = 8'd0; cmd_wdata = 32'd0; cmd_mask = 32'd0;
    cur = mk(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 32'd0, 0, 0);

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_psel", 64'(PSEL), 64'd0);
    chk("reset_penable", 64'(PENABLE), 64'd0);
    chk("reset_paddr", 64'(PADDR), 64'd0);
    chk("reset_pwdata", 64'(PWDATA), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_rsp_status", 64'(rsp_status), 64'd0);
    @(posedge PCLK);
    #1 PRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;

    // Directed: write, read, poll match on 4th read, timeout, write-with-poll, poll exhaustion.
    issue(mk(1'b1, 1'b0, 8'h00, 32'h0000_000F, 32'd0, 32'd0, 1, 0));
    wait_idle();
    issue(mk(1'b0, 1'b0, 8'h20, 32'd0, 32'd0, 32'h1234_5678, 0, 0));
    wait_idle();
    issue(mk(1'b0, 1'b1, 8'h04, 32'd0, 32'h8000_0000, 32'h0BAD_F00D, 0, 4));
    wait_idle();
    issue(mk(1'b0, 1'b0, 8'h10, 32'd0, 32'd0, 32'hDEAD_BEEF, -1, 0));
    wait_idle();
    issue(mk(1'b1, 1'b1, 8'h14, 32'hCAFE_0001, 32'hFFFF_FFFF, 32'd0, 2, 1));
    wait_idle();
    issue(mk(1'b0, 1'b1, 8'h08, 32'd0, 32'h0000_0001, 32'h5555_0000, 0, 0));
    wait_idle();

    // Back-to-back commands with the response held for 10 cycles.
    rdy_mode = 1'b0;
    a  = mk(1'b0, 1'b0, 8'h30, 32'd0, 32'd0, 32'hA5A5_1234, 1, 0);
    b  = mk(1'b1, 1'b0, 8'h34, 32'h0F0F_0F0F, 32'd0, 32'd0, 0, 0);
    ea = model(a);
    fork
      begin
        issue(a);
        issue(b);
      end
    join_none
    n = 0;
    @(negedge PCLK);
    while (!rsp_valid && n < 1000) begin
      @(negedge PCLK);
      n++;
    end
    chk("hold_rsp_arrived", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(ea.rdata));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_psel", 64'(PSEL), 64'd0);
    end
    rdy_mode = 1'b1;
    wait_idle();

    // Reset in the middle of an ACCESS phase.
    issue(mk(1'b0, 1'b0, 8'h40, 32'd0, 32'd0, 32'h7777_8888, 40, 0));
    n = 0;
    @(negedge PCLK);
    while (!(PSEL && PENABLE) && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    chk("rst_reached_access", 64'(PENABLE), 64'd1);
    #2 PRESET = 1'b1;
    #1;
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    void'(exp_q.pop_back());
    abandons++;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge PCLK);
    #1;
    issue(mk(1'b0, 1'b0, 8'h44, 32'd0, 32'd0, 32'h1357_9BDF, 1, 0));
    wait_idle();

    // Randomized command stream, queued back-to-back.
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      p.wr       = (k < 3);
      p.poll     = p.wr ? 1'($urandom) : (k >= 5 && k <= 8);
      p.addr     = 8'($urandom);
      p.wdata    = $urandom;
      p.mask     = (32'd1 << $urandom_range(0, 31)) | ($urandom & $urandom & $urandom);
      p.base     = $urandom;
      p.wait_c   = (k == 9) ? -1 : $urandom_range(0, 3);
      p.match_at = $urandom_range(1, 5);
      issue(p);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
